pipeline_hazard_ctrl: RTL and testbench

Hazard and control-flow sequencer for the 48-bit pipeline. It sits beside the IF/ID and ID/EX pipeline registers. It watches the instruction held in ID and the load/branch state coming back from EX, then drives PC-write, IF/ID-write, IF/ID-flush and ID/EX-bubble controls. It enforces a one-cycle load-use stall, holds fetch while a conditional branch is resolved, and squashes wrong-path fetches after jumps and branches.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 17 +
 rtl/pipeline_hazard_ctrl.sv | 77 +++++++
 tb/tb_pipeline_hazard_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: opcodes, widths and hazard FSM state encoding shared by the 48-bit pipeline.
package pipe_pkg;
    localparam int REG_W = 5;
    localparam int OPC_W = 6;
    localparam logic [OPC_W-1:0] OP_ADDI = 6'h0B;
    localparam logic [OPC_W-1:0] OP_J    = 6'h20;
    localparam logic [OPC_W-1:0] OP_NOP  = 6'h21;
    localparam logic [OPC_W-1:0] OP_BNE  = 6'h22;
    localparam logic [OPC_W-1:0] OP_BEQ  = 6'h23;
    localparam logic [OPC_W-1:0] OP_LV   = 6'h24;
    localparam logic [OPC_W-1:0] OP_SV   = 6'h25;
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_BR_WAIT    = 2'd2
    } state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use comparator between the ID instruction and a load in EX.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic             i_id_valid,
    input  logic             i_id_read_reg,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ex_mem_rd,
    input  logic             i_ex_wr_reg,
    output logic             o_lu
);
    // r0 is hardwired, so a load targeting it never creates a dependency
    assign o_lu = i_id_valid & i_id_read_reg & i_ex_mem_rd & i_ex_wr_reg & (i_ex_rd != '0) &
                  ((i_ex_rd == i_id_rs) | (i_ex_rd == i_id_rt));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch-wait and wrong-path squash sequencer for IF/ID and ID/EX.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int BR_TIMEOUT = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [OPC_W-1:0] id_opcode,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_read_reg,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_rd,
    input  logic             ex_wr_reg,
    input  logic             br_valid,
    input  logic             br_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state
);
    state_t     r_state, w_next;
    logic [3:0] r_tcnt;
    logic       w_lu, w_br, w_jmp, w_in_br, w_stall, w_expire, w_unused;
    hazard_detect u_hazard_detect (
        .i_id_valid    (id_valid),
        .i_id_read_reg (id_read_reg),
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .i_ex_rd       (ex_rd),
        .i_ex_mem_rd   (ex_mem_rd),
        .i_ex_wr_reg   (ex_wr_reg),
        .o_lu          (w_lu)
    );
    // br_taken steers the PC mux in the datapath; the sequencer only needs br_valid
    assign w_unused = br_taken;
    assign w_br     = id_valid & ((id_opcode == OP_BNE) | (id_opcode == OP_BEQ));
    assign w_jmp    = id_valid & (id_opcode == OP_J);
    assign w_in_br  = r_state == ST_BR_WAIT;
    assign w_stall  = (r_state == ST_RUN) & w_lu;
    assign w_expire = w_in_br & ~br_valid & (r_tcnt == 4'(BR_TIMEOUT - 1));
    assign state    = r_state;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = w_in_br ? ((br_valid | w_expire) ? ST_RUN : ST_BR_WAIT)
               : w_stall ? ST_LOAD_STALL
               : w_br    ? ST_BR_WAIT
               :           ST_RUN;
    end
    // reset forces a stalled, flushed pipeline regardless of state
    always_comb begin
        pc_write    = rst_n & ~w_stall & (w_in_br ? (br_valid | w_expire) : ~w_br);
        ifid_write  = rst_n & ~w_stall;
        ifid_flush  = ~rst_n | (~w_stall & (w_in_br | w_br | w_jmp));
        idex_bubble = ~rst_n | w_stall;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt      <= '0;
            err_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            r_tcnt <= w_in_br ? r_tcnt + 4'd1 : 4'd0;
            if (w_expire) err_timeout <= 1'b1;
            if (!pc_write && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors feeding a scoreboard queue checked by a negedge monitor.
module tb_pipeline_hazard_ctrl;
  import pipe_pkg::*;
  localparam logic [3:0] NORM = 4'b1100;
  localparam logic [3:0] RST  = 4'b0011;
  localparam logic [3:0] LU   = 4'b0001;
  localparam logic [3:0] BR   = 4'b0110;
  localparam logic [3:0] BRD  = 4'b1110;
  localparam logic [3:0] JMP  = 4'b1110;
  logic clk = 0, rst_n = 0;
  logic id_valid, id_read_reg, ex_mem_rd, ex_wr_reg, br_valid, br_taken;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, err_timeout;
  logic [31:0] stall_cnt;
  logic [1:0] state;
  typedef struct {
    string       nm;
    logic [3:0]  ctl;
    logic        err;
    logic [31:0] cnt;
    logic [1:0]  st;
  } exp_t;
  exp_t q[$];
  exp_t m_e;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.BR_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_read_reg(id_read_reg), .ex_rd(ex_rd),
    .ex_mem_rd(ex_mem_rd), .ex_wr_reg(ex_wr_reg), .br_valid(br_valid), .br_taken(br_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .err_timeout(err_timeout), .stall_cnt(stall_cnt), .state(state)
  );
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      n_chk++;
      if ({pc_write, ifid_write, ifid_flush, idex_bubble, err_timeout, stall_cnt, state} !==
          {m_e.ctl, m_e.err, m_e.cnt, m_e.st}) begin
        n_err++;
        $display("FAIL %s: got pc/iw/fl/bb=%b err=%b cnt=%0d st=%0d, want pc/iw/fl/bb=%b err=%b cnt=%0d st=%0d",
                 m_e.nm, {pc_write, ifid_write, ifid_flush, idex_bubble}, err_timeout, stall_cnt, state,
                 m_e.ctl, m_e.err, m_e.cnt, m_e.st);
      end
    end
  end
  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rr, input logic [4:0] erd, input logic mr, input logic wr, input logic bv);
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_read_reg = rr;
    ex_rd = erd; ex_mem_rd = mr; ex_wr_reg = wr; br_valid = bv; br_taken = bv;
  endtask
  task automatic idle(input logic bv = 1'b0);
    drive(0, OP_NOP, 0, 0, 0, 0, 0, 0, bv);
  endtask
  task automatic chk(input string nm, input logic [3:0] ctl, input logic err, input int cnt, input logic [1:0] st);
    exp_t e;
    e.nm = nm; e.ctl = ctl; e.err = err; e.cnt = cnt; e.st = st;
    q.push_back(e);
    @(posedge clk); #1;
  endtask
  initial begin
    idle();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) chk("reset", RST, 0, 0, 0);
    rst_n = 1;
    #1;
    n_chk++;
    if (stall_cnt !== '0 || state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: stall_cnt=%0d state=%0d, want 0 0", stall_cnt, state);
    end
    chk("post_reset", NORM, 0, 0, 0);
    drive(1, OP_ADDI, 5, 0, 1, 5, 1, 1, 0);
    chk("lu_rs", LU, 0, 0, 0);
    chk("lu_load_stall", NORM, 0, 1, 1);
    idle();
    chk("lu_back_run", NORM, 0, 1, 0);
    drive(1, OP_ADDI, 0, 0, 1, 0, 1, 1, 0);
    chk("lu_r0_none", NORM, 0, 1, 0);
    drive(1, OP_ADDI, 0, 7, 1, 7, 1, 1, 0);
    chk("lu_rt", LU, 0, 1, 0);
    idle();
    chk("lu_rt_ls", NORM, 0, 2, 1);
    drive(1, OP_ADDI, 0, 7, 0, 7, 1, 1, 0);
    chk("no_read_reg", NORM, 0, 2, 0);
    drive(1, OP_ADDI, 0, 7, 1, 7, 1, 0, 0);
    chk("no_wr_reg", NORM, 0, 2, 0);
    drive(1, OP_BEQ, 0, 0, 0, 0, 0, 0, 0);
    chk("beq_decode", BR, 0, 2, 0);
    idle();
    chk("beq_wait1", BR, 0, 3, 2);
    idle(1);
    chk("beq_resolve", BRD, 0, 4, 2);
    chk("brv_in_run", NORM, 0, 4, 0);
    drive(1, OP_J, 0, 0, 0, 0, 0, 0, 0);
    chk("jump", JMP, 0, 4, 0);
    drive(0, OP_BEQ, 0, 0, 0, 0, 0, 0, 0);
    chk("beq_invalid", NORM, 0, 4, 0);
    drive(1, OP_BNE, 0, 0, 0, 0, 0, 0, 0);
    chk("to_decode", BR, 0, 4, 0);
    idle();
    chk("to_wait1", BR, 0, 5, 2);
    chk("to_wait2", BR, 0, 6, 2);
    chk("to_wait3", BR, 0, 7, 2);
    chk("to_expire", BRD, 0, 8, 2);
    chk("to_err_set", NORM, 1, 8, 0);
    n_chk++;
    if (err_timeout !== 1'b1 || state !== 2'd0) begin
      n_err++;
      $display("FAIL expired_wait: err_timeout=%b state=%0d, want 1 0", err_timeout, state);
    end
    idle(1);
    chk("to_err_sticky", NORM, 1, 8, 0);
    drive(1, OP_BEQ, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_decode", BR, 1, 8, 0);
    idle();
    chk("mid_wait1", BR, 1, 9, 2);
    rst_n = 0;
    chk("mid_reset", RST, 0, 0, 0);
    chk("mid_reset2", RST, 0, 0, 0);
    rst_n = 1;
    chk("mid_release", NORM, 0, 0, 0);
    drive(1, OP_BEQ, 0, 0, 0, 0, 0, 0, 0);
    chk("tie_decode", BR, 0, 0, 0);
    idle();
    chk("tie_wait1", BR, 0, 1, 2);
    chk("tie_wait2", BR, 0, 2, 2);
    chk("tie_wait3", BR, 0, 3, 2);
    idle(1);
    chk("tie_resolve", BRD, 0, 4, 2);
    idle();
    chk("tie_no_err", NORM, 0, 4, 0);
    drive(1, OP_BNE, 5, 0, 1, 5, 1, 1, 0);
    chk("dep_bubble", LU, 0, 4, 0);
    chk("dep_ls_branch", BR, 0, 5, 1);
    idle();
    chk("dep_wait1", BR, 0, 6, 2);
    idle(1);
    chk("dep_resolve", BRD, 0, 7, 2);
    idle();
    chk("dep_run", NORM, 0, 7, 0);
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
